prbsgen_parallel_fab: RTL and testbench
=======================================

// Module: prbsgen_parallel_fab
// PURPOSE
// - Parallel PRBS generator, transmit end of the fabric PRBS link test: emits NBITS bits/clock of
//   the X^POLY2 + X^POLY1 + 1 sequence so the parallel PRBS checker at the far end locks error-free.
// - Sits in the IOD generic TX test path ahead of the serializer.
// - Adds seed load, single-word error injection and a generated-word counter for bring-up.
// PARAMETERS
// - NBITS  4   word width per clock; must be >= POLY2
// - POLY2  3   highest polynomial tap (LFSR length)
// - POLY1  1   lower polynomial tap; 0 < POLY1 < POLY2
// - CNT_W  32  width of generated-word counter
// PORTS
// - clk_i          in   1           fabric clock
// - resetn_i       in   1           asynchronous, active-low reset
// - prbs_en_i      in   1           level; high = generate, low = idle
// - seed_i         in   POLY2       LFSR seed, sampled on IDLE->RUN
// - err_inj_i      in   1           one-cycle request to corrupt one output word
// - data_out_o     out  NBITS       PRBS word; bit NBITS-1 is oldest in time, bit 0 is newest
// - data_valid_o   out  1           data_out_o holds a generated word
// - inj_done_o     out  1           one-cycle pulse aligned with the corrupted word
// - word_cnt_o     out  CNT_W       count of words generated since the last IDLE->RUN transition
// BEHAVIOUR
// - Reset values: data_out_o=0, data_valid_o=0, inj_done_o=0, word_cnt_o=0; FSM=IDLE; lfsr_q='1; inj_pend=0.
// - FSM states: IDLE, LOAD, RUN.
//   - IDLE->LOAD when prbs_en_i=1. On this edge lfsr_q<=seed_i, or all-ones if seed_i==0 (no lockup).
//     Also word_cnt_o<=0.
//   - LOAD->RUN unconditionally if prbs_en_i=1, else LOAD->IDLE.
//   - RUN->IDLE when prbs_en_i=0.
//   - Latency: en sampled high at edge k gives the first valid word after edge k+2.
// - Next word, each RUN cycle: s = {lfsr_q, w}, with s indexed NBITS+POLY2-1..0.
//   - Evaluate i = NBITS-1 downto 0: w[i] = s[i+POLY2] ^ s[i+POLY2-POLY1].
//   - At the edge: data_out_o<=w, lfsr_q<=w[POLY2-1:0], data_valid_o<=1.
//   - This output satisfies the checker relation d[i]^d[i+POLY2-POLY1]^d[i+POLY2]==0 across word boundaries.
// - Leaving RUN: data_valid_o<=0; data_out_o holds its last value; lfsr_q is kept.
//   The next LOAD reseeds lfsr_q.
// - Error injection:
//   - err_inj_i sets inj_pend in any state; a request while inj_pend=1 merges with it.
//   - On the next RUN output edge: data_out_o<=w ^ 1 (bit 0 flipped), inj_done_o<=1, inj_pend<=0.
//   - The flip is applied to the output only; lfsr_q still loads the uncorrupted w[POLY2-1:0].
//   - If err_inj_i and the consuming edge coincide, the word is corrupted and inj_pend stays 1,
//     so exactly one more word is corrupted later.
// - word_cnt_o increments by 1 on each RUN output edge and saturates at all-ones.
// - Asserting resetn_i mid-run forces reset values immediately, with no partial word.
// STRUCTURE
// - Shared package prbs_pkg:
//   - default POLY2/POLY1 constants
//   - FSM state enum {IDLE, LOAD, RUN}
//   - function prbs_next_word(lfsr, NBITS) returning w
// - One natural sub-module, prbsgen_lfsr_step: a purely combinational {lfsr_q} -> {w, lfsr_next}
//   block shared with future checker rewrites.
// - The FSM, injection logic and counter stay in the top.
// TESTING (NBITS=4, POLY2=3, POLY1=1)
// - Seed 3'b001, en high -> first words 0111, 0010, 1110, 0101; 7-word period repeats; word_cnt_o=1,2,3,4.
// - Seed 3'b000 -> identical to seed 3'b111 path; no all-zero word ever appears.
// - Loopback into the parallel checker, 1000 words -> checker error deasserts after lock and stays 0.
// - err_inj_i pulse in RUN -> exactly one word has bit 0 inverted, inj_done_o high that cycle;
//   the checker flags and then recovers; the uncorrupted sequence continues unchanged.
// - Drop en mid-run, re-raise with a new seed -> data_valid_o=0 for 2 cycles, word_cnt_o restarts
//   at 1, sequence restarts from the new seed.
// - resetn_i low mid-run with inj_pend=1 -> all outputs 0, no injection after reset release.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the parallel PRBS generator and checker blocks.
// Holds the default polynomial, the control FSM encoding and the word-step function.
package prbs_pkg;

    localparam int PRBS_POLY2_DEF = 3;
    localparam int PRBS_POLY1_DEF = 1;

    // Widest word/LFSR the step function supports; index widths follow from it.
    localparam int PRBS_MAX_W  = 32;
    localparam int PRBS_IDX_W  = $clog2(PRBS_MAX_W);
    localparam int PRBS_SIDX_W = $clog2(2 * PRBS_MAX_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } prbs_state_e;

    // Builds s = {lfsr, w} and fills w from its oldest bit down to its newest,
    // so bits produced earlier in the same word feed the later ones.
    function automatic logic [PRBS_MAX_W-1:0] prbs_next_word(
        input logic [PRBS_MAX_W-1:0] lfsr,
        input int                    nbits,
        input int                    poly2,
        input int                    poly1
    );
        logic [2*PRBS_MAX_W-1:0] s;
        s = '0;
        for (int j = 0; j < PRBS_MAX_W; j++) begin
            if (j < poly2) begin
                s[PRBS_SIDX_W'(j + nbits)] = lfsr[PRBS_IDX_W'(j)];
            end
        end
        for (int i = PRBS_MAX_W - 1; i >= 0; i--) begin
            if (i < nbits) begin
                s[PRBS_SIDX_W'(i)] = s[PRBS_SIDX_W'(i + poly2)] ^ s[PRBS_SIDX_W'(i + poly2 - poly1)];
            end
        end
        return s[PRBS_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/prbsgen_lfsr_step.sv
// Purely combinational PRBS word step: current LFSR state in, next word and next state out.
// The next state is simply the newest POLY2 bits of the word just produced.
module prbsgen_lfsr_step
    import prbs_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int POLY2 = PRBS_POLY2_DEF,
    parameter int POLY1 = PRBS_POLY1_DEF
) (
    input  logic [POLY2-1:0] lfsr_i,
    output logic [NBITS-1:0] word_o,
    output logic [POLY2-1:0] lfsr_next_o
);

    always_comb begin
        word_o = NBITS'(prbs_next_word(PRBS_MAX_W'(lfsr_i), NBITS, POLY2, POLY1));
    end

    assign lfsr_next_o = word_o[POLY2-1:0];

endmodule

// File: rtl/prbsgen_parallel_fab.sv
// Parallel PRBS generator for the fabric link test: seeds, runs and emits NBITS bits per clock,
// with single-word bit-0 error injection and a saturating generated-word counter.
module prbsgen_parallel_fab
    import prbs_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int POLY2 = PRBS_POLY2_DEF,
    parameter int POLY1 = PRBS_POLY1_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             prbs_en_i,
    input  logic [POLY2-1:0] seed_i,
    input  logic             err_inj_i,
    output logic [NBITS-1:0] data_out_o,
    output logic             data_valid_o,
    output logic             inj_done_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    prbs_state_e      state_q, state_d;
    logic [POLY2-1:0] lfsr_q, lfsr_d;
    logic [NBITS-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             inj_done_q, inj_done_d;
    logic             inj_pend_q, inj_pend_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [NBITS-1:0] step_word;
    logic [POLY2-1:0] step_lfsr_next;

    prbsgen_lfsr_step #(
        .NBITS(NBITS),
        .POLY2(POLY2),
        .POLY1(POLY1)
    ) u_lfsr_step (
        .lfsr_i      (lfsr_q),
        .word_o      (step_word),
        .lfsr_next_o (step_lfsr_next)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        inj_done_d   = 1'b0;
        inj_pend_d   = inj_pend_q | err_inj_i;
        word_cnt_d   = word_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (prbs_en_i) begin
                    state_d    = ST_LOAD;
                    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
                    lfsr_d     = (seed_i == '0) ? '1 : seed_i;
                    word_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                state_d = prbs_en_i ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (prbs_en_i) begin
                    // The flip corrupts the output only; the LFSR keeps the clean word.
                    data_out_d   = step_word ^ NBITS'(inj_pend_q);
                    data_valid_d = 1'b1;
                    inj_done_d   = inj_pend_q;
                    if (inj_pend_q) begin
                        inj_pend_d = err_inj_i;
                    end
                    lfsr_d     = step_lfsr_next;
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: every flop here is a plain register with a defined reset value; there is no memory array.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= '1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            inj_done_q   <= 1'b0;
            inj_pend_q   <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            inj_done_q   <= inj_done_d;
            inj_pend_q   <= inj_pend_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign inj_done_o   = inj_done_q;
    assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_prbsgen_parallel_fab.sv
// Directed bench for prbsgen_parallel_fab at NBITS=4, X^3+X^1+1, with a 4-bit counter
// so saturation is reachable. Expected words are the hand-derived 7-word period.
module tb_prbsgen_parallel_fab;

    logic       clk;
    logic       resetn;
    logic       en;
    logic [2:0] seed;
    logic       inj;
    logic [3:0] data_out;
    logic       data_valid;
    logic       inj_done;
    logic [3:0] word_cnt;

    int errors = 0;
    int checks = 0;

    // Period of the sequence starting from LFSR state 3'b001.
    logic [3:0] seq [7] = '{4'h7, 4'h2, 4'hE, 4'h5, 4'hC, 4'hB, 4'h9};
    int         ph;
    int         exp_cnt;
    logic [3:0] prev;
    logic [3:0] last;

    prbsgen_parallel_fab #(
        .NBITS(4),
        .POLY2(3),
        .POLY1(1),
        .CNT_W(4)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .prbs_en_i    (en),
        .seed_i       (seed),
        .err_inj_i    (inj),
        .data_out_o   (data_out),
        .data_valid_o (data_valid),
        .inj_done_o   (inj_done),
        .word_cnt_o   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Chain relation the far-end checker uses: d[i]^d[i+2]^d[i+3]==0 over {prev, cur}.
    function automatic logic rel_ok(input logic [3:0] p, input logic [3:0] c);
        logic [7:0] t;
        t = {p, c};
        for (int i = 0; i < 4; i++) begin
            if ((t[i] ^ t[i+2] ^ t[i+3]) != 1'b0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One RUN output edge: checks word (optionally bit-0 flipped), valid, inj_done, counter.
    task automatic word(input string tag, input logic flip, input logic done);
        step();
        exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
        check({tag, "_data"},  32'(data_out),   32'(seq[ph] ^ {3'b000, flip}));
        check({tag, "_valid"}, 32'(data_valid), 32'(1));
        check({tag, "_done"},  32'(inj_done),   32'(done));
        check({tag, "_cnt"},   32'(word_cnt),   32'(exp_cnt));
        ph = (ph + 1) % 7;
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        seed   = 3'b000;
        inj    = 1'b0;
        ph     = 0;
        exp_cnt = 0;
        repeat (3) @(negedge clk);

        check("rst_data",  32'(data_out),   32'(0));
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_done",  32'(inj_done),   32'(0));
        check("rst_cnt",   32'(word_cnt),   32'(0));

        resetn = 1'b1;
        step();
        check("idle_valid", 32'(data_valid), 32'(0));

        // Seed 001: two cycles of latency, then the period from seq[0].
        seed = 3'b001;
        en   = 1'b1;
        step();
        check("load_valid", 32'(data_valid), 32'(0));
        check("load_cnt",   32'(word_cnt),   32'(0));
        step();
        check("run_entry_valid", 32'(data_valid), 32'(0));
        ph = 0;
        exp_cnt = 0;
        prev = 4'h0;
        for (int n = 1; n <= 18; n++) begin
            word("seed1", 1'b0, 1'b0);
            if (n > 1) check("relation", 32'(rel_ok(prev, data_out)), 32'(1));
            prev = data_out;
        end

        // Single injection: request edge is clean, following word has bit 0 flipped.
        inj = 1'b1;
        word("inj_req", 1'b0, 1'b0);
        inj = 1'b0;
        word("inj_hit", 1'b1, 1'b1);
        word("inj_after1", 1'b0, 1'b0);
        word("inj_after2", 1'b0, 1'b0);

        // Request coinciding with the consuming edge corrupts exactly one more word.
        inj = 1'b1;
        word("merge_req", 1'b0, 1'b0);
        word("coincide_hit", 1'b1, 1'b1);
        inj = 1'b0;
        word("coincide_again", 1'b1, 1'b1);
        word("coincide_clean", 1'b0, 1'b0);
        last = data_out;

        // Drop enable, then re-raise with seed 010 (which starts at seq[2]).
        en = 1'b0;
        step();
        check("drop_valid", 32'(data_valid), 32'(0));
        check("drop_hold",  32'(data_out),   32'(last));
        check("drop_done",  32'(inj_done),   32'(0));
        step();
        check("idle2_valid", 32'(data_valid), 32'(0));
        seed = 3'b010;
        en   = 1'b1;
        step();
        check("reload_valid", 32'(data_valid), 32'(0));
        check("reload_cnt",   32'(word_cnt),   32'(0));
        step();
        check("reload_run_valid", 32'(data_valid), 32'(0));
        ph = 2;
        exp_cnt = 0;
        word("reseed0", 1'b0, 1'b0);
        word("reseed1", 1'b0, 1'b0);
        word("reseed2", 1'b0, 1'b0);

        // Seed 000 behaves as 111, which starts at seq[1]; a full period, never zero.
        en = 1'b0;
        step();
        seed = 3'b000;
        en   = 1'b1;
        step();
        step();
        ph = 1;
        exp_cnt = 0;
        for (int n = 0; n < 7; n++) begin
            word("seed0", 1'b0, 1'b0);
        end

        // Reset mid-run with an injection pending: nothing survives the reset.
        inj = 1'b1;
        word("pre_rst_req", 1'b0, 1'b0);
        inj = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_data",  32'(data_out),   32'(0));
        check("midrst_valid", 32'(data_valid), 32'(0));
        check("midrst_done",  32'(inj_done),   32'(0));
        check("midrst_cnt",   32'(word_cnt),   32'(0));
        @(negedge clk);
        resetn = 1'b1;
        seed   = 3'b001;
        step();
        step();
        ph = 0;
        exp_cnt = 0;
        word("post_rst0", 1'b0, 1'b0);
        word("post_rst1", 1'b0, 1'b0);
        word("post_rst2", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
